stopwatch_lap_timer: RTL



---
 rtl/stopwatch_lap_timer_if.sv | 25 ++
 rtl/stopwatch_lap_timer.sv | 108 ++++++++++
 2 files changed

// File: rtl/stopwatch_lap_timer_if.sv
// stopwatch_lap_timer_if: button, mode and preset inputs plus time, lap and status outputs of the stopwatch
interface stopwatch_lap_timer_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int LW = $clog2(LAP_DEPTH);
  logic btn_run_stop;
  logic btn_clear;
  logic btn_lap;
  logic i_mode;
  logic [23:0] i_load_data;
  logic [LW-1:0] i_lap_sel;
  logic [23:0] o_time_data;
  logic [23:0] o_lap_data;
  logic [LW:0] o_lap_count;
  logic o_expired;
  logic [1:0] o_state;
  modport master (
    output btn_run_stop, btn_clear, btn_lap, i_mode, i_load_data, i_lap_sel,
    input o_time_data, o_lap_data, o_lap_count, o_expired, o_state
  );
  modport slave (
    input btn_run_stop, btn_clear, btn_lap, i_mode, i_load_data, i_lap_sel,
    output o_time_data, o_lap_data, o_lap_count, o_expired, o_state
  );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: up/down stopwatch with circular lap buffer and countdown expiry pulse
module stopwatch_lap_timer #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int LAP_DEPTH = 4,
  parameter int HOUR_MAX = 24
) (
  input logic clk,
  input logic rst,
  stopwatch_lap_timer_if.slave bus
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int LW = $clog2(LAP_DEPTH);
  localparam logic [6:0] MS_MAX = 7'(TICK_HZ - 1);
  localparam logic [4:0] HR_MAX = 5'(HOUR_MAX - 1);
  localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);
  localparam logic [LW:0] LAP_FULL = (LW+1)'(LAP_DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10, DONE = 2'b11} state_t;
  state_t state;
  logic mode;
  logic expired;
  logic [PW-1:0] presc;
  logic [4:0] hr;
  logic [5:0] mn, sc;
  logic [6:0] ms;
  logic [23:0] cur, up, dn, ld, lap_q;
  logic [23:0] mem [LAP_DEPTH];
  logic [LW-1:0] wr_ptr, rd_idx;
  logic [LW:0] lap_cnt;
  logic c0, c1, c2, b0, b1, b2, tick, last, lap_we;
  always_comb begin
    cur = {hr, mn, sc, ms};
    c0 = ms == MS_MAX;
    c1 = c0 && sc == 6'd59;
    c2 = c1 && mn == 6'd59;
    b0 = ms == 7'd0;
    b1 = b0 && sc == 6'd0;
    b2 = b1 && mn == 6'd0;
    up = {c2 ? (hr == HR_MAX ? 5'd0 : hr + 5'd1) : hr,
          c1 ? (mn == 6'd59 ? 6'd0 : mn + 6'd1) : mn,
          c0 ? (sc == 6'd59 ? 6'd0 : sc + 6'd1) : sc,
          c0 ? 7'd0 : ms + 7'd1};
    dn = {b2 ? hr - 5'd1 : hr,
          b1 ? (b2 ? 6'd59 : mn - 6'd1) : mn,
          b0 ? (b1 ? 6'd59 : sc - 6'd1) : sc,
          b0 ? MS_MAX : ms - 7'd1};
    ld = {bus.i_load_data[23:19] > HR_MAX ? HR_MAX : bus.i_load_data[23:19],
          bus.i_load_data[18:13] > 6'd59 ? 6'd59 : bus.i_load_data[18:13],
          bus.i_load_data[12:7] > 6'd59 ? 6'd59 : bus.i_load_data[12:7],
          bus.i_load_data[6:0] > MS_MAX ? MS_MAX : bus.i_load_data[6:0]};
    tick = state == RUN && presc == PS_MAX;
    last = mode && cur == 24'd1;
    lap_we = bus.btn_lap && !bus.btn_clear && !bus.btn_run_stop && !mode && (state == RUN || state == STOP);
    rd_idx = wr_ptr - bus.i_lap_sel - LW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode <= 1'b0;
      expired <= 1'b0;
      presc <= '0;
      {hr, mn, sc, ms} <= '0;
      wr_ptr <= '0;
      lap_cnt <= '0;
      lap_q <= '0;
    end else begin
      expired <= 1'b0;
      lap_q <= {1'b0, bus.i_lap_sel} < lap_cnt ? mem[rd_idx] : '0;
      if (bus.btn_clear) begin
        state <= IDLE;
        mode <= bus.i_mode;
        presc <= '0;
        {hr, mn, sc, ms} <= bus.i_mode ? ld : '0;
        wr_ptr <= '0;
        lap_cnt <= '0;
      end else begin
        if (bus.btn_run_stop && state == IDLE && !(bus.i_mode && cur == '0)) begin
          state <= RUN;
          mode <= bus.i_mode;
        end else if (bus.btn_run_stop && state == RUN)
          state <= STOP;
        else if (bus.btn_run_stop && state == STOP)
          state <= RUN;
        presc <= state == RUN ? (tick ? '0 : presc + PW'(1)) : state == STOP ? presc : '0;
        // expiry overrides a stop requested on the same final tick
        if (tick) begin
          {hr, mn, sc, ms} <= mode ? dn : up;
          if (last) begin
            state <= DONE;
            expired <= 1'b1;
          end
        end
        if (lap_we) begin
          wr_ptr <= wr_ptr + LW'(1);
          lap_cnt <= lap_cnt == LAP_FULL ? lap_cnt : lap_cnt + (LW+1)'(1);
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && lap_we) mem[wr_ptr] <= cur;
  assign bus.o_time_data = cur;
  assign bus.o_lap_data = lap_q;
  assign bus.o_lap_count = lap_cnt;
  assign bus.o_expired = expired;
  assign bus.o_state = state;
endmodule
